rc5_encrypt: RTL and testbench
==============================

// Module: rc5_encrypt
// PURPOSE
//  Iterative RC5-16/r/b block-encryption core, directly downstream of keygen.
//  - Consumes the expanded subkey table S[0:T-1] and keygen's one-cycle ready pulse.
//  - Encrypts one 32-bit plaintext block {B,A} per request over valid/ready handshakes.
//  - Executes one half-round per clock.
// PARAMETERS
//  W_SIZE      16   word width in bits; rotate amount uses the low $clog2(W_SIZE) bits
//  T_MAX       34   subkey table depth = 2*(MAX_ROUNDS+1)
//  MAX_ROUNDS  16   largest supported round count
// PORTS
//  clk           in   1         clock
//  rst           in   1         asynchronous, active-high reset
//  subkeys       in   W x T_MAX subkey table S[0:T_MAX-1] from keygen; stable while keygen idle
//  subkeys_valid in   1         keygen ready pulse: table now valid
//  key_start     in   1         keygen start: table about to be overwritten
//  num_rounds    in   5         round count r; sampled on accept
//  in_valid      in   1         plaintext valid
//  in_ready      out  1         core can accept plaintext
//  in_data       in   2*W       plaintext; [W-1:0]=A, [2W-1:W]=B
//  out_valid     out  1         ciphertext valid
//  out_ready     in   1         consumer accepts ciphertext
//  out_data      out  2*W       ciphertext; [W-1:0]=A, [2W-1:W]=B
// BEHAVIOUR
//  Reset (async, rst=1)
//   - state=IDLE, key_loaded=0, A=B=0, half counter h=0.
//   - in_ready=0, out_valid=0, out_data=0.
//  Key tracking
//   - key_loaded is set by subkeys_valid and cleared by key_start.
//   - key_start has priority if both are asserted in the same cycle.
//  in_ready = (state==IDLE) && key_loaded && !key_start. Purely combinational.
//  FSM states: IDLE, RUN, OUT.
//  IDLE
//   - Accept on in_valid && in_ready.
//   - On accept: A <= in_A + S[0]; B <= in_B + S[1] (mod 2^W).
//   - On accept: R <= min(num_rounds, MAX_ROUNDS); h <= 0.
//   - Next state: OUT if R==0, else RUN.
//  RUN (one half-round per cycle, h = 0 .. 2R-1)
//   - h even: A <= rotl(A^B, B[3:0]) + S[h+2].
//   - h odd:  B <= rotl(B^A, A[3:0]) + S[h+2]. The A used here is the updated A.
//   - h <= h+1. At h==2R-1, go to OUT.
//  OUT
//   - out_valid=1; out_data={B,A}, held stable until out_ready.
//   - On out_ready: go to IDLE. in_ready can rise the next cycle.
//  Timing
//   - Latency: out_valid rises 2R cycles after the accept edge (R=0: the cycle after accept).
//   - Throughput: one block per 2R+2 cycles when out_ready is held at 1.
//  Arithmetic
//   - All additions wrap mod 2^W.
//   - rotl by 0 is identity; rotate amount is the low 4 bits of the operand.
//  Boundary conditions
//   - num_rounds > 16 is clamped to 16.
//   - num_rounds and in_data changes after accept are ignored.
//   - key_start in RUN or OUT aborts: next state IDLE, out_valid drops with no handshake,
//     and the block is discarded.
//   - key_start in IDLE only clears key_loaded.
//   - subkeys_valid while busy only sets key_loaded; the current block completes normally.
//   - in_valid while in_ready=0 is ignored; no request is queued.
//   - Reset asserted mid-operation returns all state to reset values immediately.
// TESTING
//  1. All subkeys 0, pt 0x0000_0000, r=12 -> ct 0x0000_0000; out_valid exactly 24 cycles
//     after accept.
//  2. r=0, S0=0x1111, S1=0x2222, A=0x0001, B=0x0002 -> out_data=0x2224_1112;
//     out_valid the cycle after accept.
//  3. r=1, S2=0x0001, all other S=0, pt 0 -> A=0x0001, B=0x0002 (out_data=0x0002_0001);
//     latency 2.
//  4. Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_data stable, in_ready=0;
//     release -> handshake, in_ready=1 next cycle.
//  5. key_start pulse at h=3 of r=8 -> out_valid never rises, in_ready=0 until subkeys_valid,
//     then accepts normally.
//  6. num_rounds=20 -> behaves as r=16 (latency 32).
//     Then 200 random blocks with real keygen output vs a C RC5-16 model -> bit-exact match.

Source files
------------

// File: rtl/rc5_encrypt_if.sv
// Plaintext/ciphertext handshake bundle for the RC5-16 encryption core.
interface rc5_encrypt_if #(
    parameter int unsigned W_SIZE = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*W_SIZE-1:0]   in_data;
    logic [4:0]            num_rounds;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*W_SIZE-1:0]   out_data;

    modport master (
        output in_valid, in_data, num_rounds, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, num_rounds, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/rc5_encrypt.sv
// Iterative RC5-16/r/b encryption core: one half-round per clock using the
// subkey table produced by keygen.
module rc5_encrypt #(
    parameter int unsigned W_SIZE     = 16,
    parameter int unsigned T_MAX      = 34,
    parameter int unsigned MAX_ROUNDS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [T_MAX-1:0][W_SIZE-1:0]  subkeys,
    input  logic                          subkeys_valid,
    input  logic                          key_start,
    rc5_encrypt_if.slave                  bus
);
    localparam int unsigned RW = $clog2(W_SIZE);
    localparam int unsigned NW = 5;
    localparam int unsigned HW = $clog2(2 * MAX_ROUNDS);
    localparam int unsigned IW = $clog2(T_MAX);

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t              state, state_next;
    logic                key_loaded;
    logic [W_SIZE-1:0]   a, b;
    logic [HW-1:0]       h;
    logic [NW-1:0]       rounds;
    logic [NW-1:0]       r_in;
    logic                in_ready_c;
    logic                accept;
    logic                h_done;
    logic [IW-1:0]       idx;
    logic [W_SIZE-1:0]   mix_a, mix_b;

    function automatic logic [W_SIZE-1:0] rotl(input logic [W_SIZE-1:0] x,
                                               input logic [RW-1:0]     n);
        logic [2*W_SIZE-1:0] d;
        d = {x, x} << n;
        return d[2*W_SIZE-1:W_SIZE];
    endfunction

    assign r_in   = (bus.num_rounds > NW'(MAX_ROUNDS)) ? NW'(MAX_ROUNDS) : bus.num_rounds;
    assign accept = bus.in_valid && in_ready_c;
    assign h_done = ((HW+1)'(h) + (HW+1)'(1)) == (HW+1)'({rounds, 1'b0});
    assign idx    = IW'(h) + IW'(2);
    // Odd half-rounds see the A written on the previous (even) half-round.
    assign mix_a  = rotl(a ^ b, b[RW-1:0]) + subkeys[idx];
    assign mix_b  = rotl(b ^ a, a[RW-1:0]) + subkeys[idx];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; key_start abandons any block in flight
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = (r_in == '0) ? OUT : RUN;
            RUN: begin
                if (key_start)   state_next = IDLE;
                else if (h_done) state_next = OUT;
            end
            OUT: begin
                if (key_start || bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready_c    = (state == IDLE) && key_loaded && !key_start;
        bus.in_ready  = in_ready_c;
        bus.out_valid = (state == OUT);
        bus.out_data  = {b, a};
    end

    // Subkey table validity tracking; a pending overwrite wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                key_loaded <= 1'b0;
        else if (key_start)     key_loaded <= 1'b0;
        else if (subkeys_valid) key_loaded <= 1'b1;
    end

    // Block datapath: pre-whitening on accept, then alternating half-rounds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a      <= '0;
            b      <= '0;
            h      <= '0;
            rounds <= '0;
        end else if (accept) begin
            a      <= bus.in_data[W_SIZE-1:0] + subkeys[0];
            b      <= bus.in_data[2*W_SIZE-1:W_SIZE] + subkeys[1];
            rounds <= r_in;
            h      <= '0;
        end else if (state == RUN) begin
            if (!h[0]) a <= mix_a;
            else       b <= mix_b;
            h <= h + HW'(1);
        end
    end
endmodule

// File: tb/tb_rc5_encrypt.sv
// Self-checking bench for rc5_encrypt: directed vector table, corner-case
// sequences and random blocks against a reference RC5-16 model.
module tb_rc5_encrypt;
    logic              clk = 1'b0;
    logic              rst;
    logic [33:0][15:0] subkeys;
    logic              subkeys_valid;
    logic              key_start;
    logic [15:0]       sk [34];

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q [$];

    rc5_encrypt_if bus ();

    rc5_encrypt dut (
        .clk           (clk),
        .rst           (rst),
        .subkeys       (subkeys),
        .subkeys_valid (subkeys_valid),
        .key_start     (key_start),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    always_comb for (int i = 0; i < 34; i++) subkeys[i] = sk[i];

    typedef struct {
        int          key_sel;
        logic [31:0] pt;
        logic [4:0]  nr;
        logic [31:0] exp_ct;
        int          exp_lat;
    } vec_t;

    vec_t tbl [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
        if (n == 0) return x;
        return (x << n) | (x >> (16 - n));
    endfunction

    // Textbook RC5 encryption loop, full rounds rather than half-rounds
    function automatic logic [31:0] model(input logic [31:0] pt, input int nr);
        int r;
        logic [15:0] ma, mb;
        r  = (nr > 16) ? 16 : nr;
        ma = pt[15:0] + sk[0];
        mb = pt[31:16] + sk[1];
        for (int i = 1; i <= r; i++) begin
            ma = rotl16(ma ^ mb, int'(mb % 16)) + sk[2*i];
            mb = rotl16(mb ^ ma, int'(ma % 16)) + sk[2*i+1];
        end
        return {mb, ma};
    endfunction

    task automatic load_keys(input int sel);
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        for (int i = 0; i < 34; i++) begin
            case (sel)
                1:       sk[i] = (i == 0) ? 16'h1111 : (i == 1) ? 16'h2222 : 16'h0000;
                2:       sk[i] = (i == 2) ? 16'h0001 : 16'h0000;
                3:       sk[i] = 16'($urandom);
                default: sk[i] = 16'h0000;
            endcase
        end
        subkeys_valid = 1'b1;
        tick();
        subkeys_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int w = 0;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!bus.in_ready) check({name, " in_ready wait"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_block(input string name, input logic [31:0] pt, input logic [4:0] nr,
                             input logic [31:0] exp, input int exp_lat);
        int lat = 0;
        wait_ready(name);
        bus.in_valid   = 1'b1;
        bus.in_data    = pt;
        bus.num_rounds = nr;
        tick();
        sb_q.push_back(exp);
        // Post-accept input changes must have no effect
        bus.in_valid   = 1'b0;
        bus.in_data    = ~pt;
        bus.num_rounds = 5'd3;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        bus.out_ready = 1'b1;
        check({name, " ct"}, bus.out_data, sb_q.pop_front());
        tick();
        bus.out_ready = 1'b0;
        check({name, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] pt;
        logic [4:0]  nr;

        tbl[0] = '{0, 32'h0000_0000, 5'd12, 32'h0000_0000, 24};
        tbl[1] = '{1, 32'h0002_0001, 5'd0,  32'h2224_1112, 0};
        tbl[2] = '{2, 32'h0000_0000, 5'd1,  32'h0002_0001, 2};
        tbl[3] = '{2, 32'h0000_0000, 5'd2,  32'hE000_000C, 4};
        tbl[4] = '{0, 32'h0000_0000, 5'd20, 32'h0000_0000, 32};

        rst = 1'b1;
        subkeys_valid = 1'b0;
        key_start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.num_rounds = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 34; i++) sk[i] = '0;
        tick();
        tick();
        check("reset in_ready", 32'(bus.in_ready), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data", bus.out_data, 32'd0);
        rst = 1'b0;
        tick();
        check("no key in_ready", 32'(bus.in_ready), 32'd0);

        for (int v = 0; v < 5; v++) begin
            load_keys(tbl[v].key_sel);
            run_block($sformatf("vec%0d", v), tbl[v].pt, tbl[v].nr, tbl[v].exp_ct, tbl[v].exp_lat);
        end

        // Backpressure in OUT, with a subkeys_valid pulse while running
        load_keys(3);
        pt = $urandom;
        wait_ready("bp");
        bus.in_valid = 1'b1;
        bus.in_data = pt;
        bus.num_rounds = 5'd2;
        tick();
        bus.in_valid = 1'b0;
        sb_q.push_back(model(pt, 2));
        subkeys_valid = 1'b1;
        tick();
        subkeys_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("bp latency", 32'(lat), 32'd4);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp hold%0d data", c), bus.out_data, sb_q[0]);
            check($sformatf("bp hold%0d in_ready", c), 32'(bus.in_ready), 32'd0);
        end
        check("bp out_valid held", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        void'(sb_q.pop_front());
        check("bp in_ready after release", 32'(bus.in_ready), 32'd1);
        check("bp out_valid after release", 32'(bus.out_valid), 32'd0);

        // key_start mid-run discards the block
        wait_ready("abort");
        bus.in_valid = 1'b1;
        bus.in_data = $urandom;
        bus.num_rounds = 5'd8;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        bus.in_valid = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid || bus.in_ready) seen++;
            tick();
        end
        bus.in_valid = 1'b0;
        check("abort silent", 32'(seen), 32'd0);
        subkeys_valid = 1'b1;
        tick();
        subkeys_valid = 1'b0;
        check("abort reload in_ready", 32'(bus.in_ready), 32'd1);
        pt = $urandom;
        run_block("after abort", pt, 5'd5, model(pt, 5), 10);

        // Random blocks, fresh key table every 40 blocks
        for (int n = 0; n < 200; n++) begin
            if (n % 40 == 0) load_keys(3);
            pt = $urandom;
            nr = 5'($urandom_range(0, 20));
            run_block($sformatf("rand%0d", n), pt, nr, model(pt, int'(nr)),
                      2 * ((nr > 16) ? 16 : int'(nr)));
        end

        // Asynchronous reset mid-block
        wait_ready("mid rst");
        bus.in_valid = 1'b1;
        bus.in_data = $urandom;
        bus.num_rounds = 5'd16;
        tick();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1;
        #1;
        check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
        check("mid rst out_data", bus.out_data, 32'd0);
        check("mid rst in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post rst key cleared", 32'(bus.in_ready), 32'd0);
        check("post rst out_valid", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
